spi_burst_ctrl: RTL

// Host-side sequencer feeding the SPI master core. Buffers TX bytes in a FIFO,

---
 rtl/spi_burst_ctrl_if.sv | 25 ++
 rtl/spi_burst_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_burst_ctrl_if.sv
// SPI core side of the burst sequencer: the byte to send with its start strobe,
// and the received byte with its completion strobe and ready flag.
interface spi_burst_ctrl_if;
  logic [7:0] spi_din;
  logic       spi_start;
  logic [7:0] spi_dout;
  logic       spi_done_tick;
  logic       spi_ready;

  modport master (
    output spi_din,
    output spi_start,
    input  spi_dout,
    input  spi_done_tick,
    input  spi_ready
  );

  modport slave (
    input  spi_din,
    input  spi_start,
    output spi_dout,
    output spi_done_tick,
    output spi_ready
  );
endinterface

// File: rtl/spi_burst_ctrl.sv
// Host-side burst sequencer for an SPI master core. TX bytes queue in a FIFO.
// A go pulse holds one slave select low for the whole burst and launches one
// byte per core-ready window. Each echoed byte lands in an RX FIFO.
module spi_burst_ctrl #(
  parameter int ADDR_W = 3,
  parameter int NUM_SS = 4,
  parameter int CS_DLY = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_tx,
  input  logic [7:0]                  tx_data,
  input  logic                        rd_rx,
  output logic [7:0]                  rx_data,
  input  logic                        go,
  input  logic [$clog2(NUM_SS)-1:0]   ss_sel,
  output logic                        tx_full,
  output logic                        tx_empty,
  output logic                        rx_empty,
  output logic                        rx_ovf,
  output logic                        busy,
  output logic                        burst_done,
  output logic [NUM_SS-1:0]           ss_n,
  spi_burst_ctrl_if.master            spi
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int TMR_W = $clog2(CS_DLY + 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETUP  = 3'd1;
  localparam logic [2:0] LAUNCH = 3'd2;
  localparam logic [2:0] WAIT   = 3'd3;
  localparam logic [2:0] HOLD   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [NUM_SS-1:0] ss_n_q, ss_n_d;
  logic [7:0]        spi_din_q, spi_din_d;
  logic              spi_start_q, spi_start_d;
  logic              busy_q, busy_d;
  logic              burst_done_q, burst_done_d;
  logic              rx_ovf_q, rx_ovf_d;

  logic [7:0]        tx_mem_q [DEPTH];
  logic [ADDR_W-1:0] tx_wr_ptr_q, tx_wr_ptr_d;
  logic [ADDR_W-1:0] tx_rd_ptr_q, tx_rd_ptr_d;
  logic [ADDR_W:0]   tx_cnt_q, tx_cnt_d;

  logic [7:0]        rx_mem_q [DEPTH];
  logic [ADDR_W-1:0] rx_wr_ptr_q, rx_wr_ptr_d;
  logic [ADDR_W-1:0] rx_rd_ptr_q, rx_rd_ptr_d;
  logic [ADDR_W:0]   rx_cnt_q, rx_cnt_d;

  logic tx_push, tx_pop;
  logic rx_push, rx_pop, rx_write;

  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == (ADDR_W+1)'(DEPTH));
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_data  = rx_mem_q[rx_rd_ptr_q];

  assign tx_push  = wr_tx && !tx_full;
  assign rx_pop   = rd_rx && !rx_empty;
  // A full RX FIFO still accepts the incoming byte when the host frees a slot in the same cycle.
  assign rx_write = rx_push && (!rx_full_w() || rx_pop);

  function automatic logic rx_full_w();
    return (rx_cnt_q == (ADDR_W+1)'(DEPTH));
  endfunction

  assign ss_n          = ss_n_q;
  assign busy          = busy_q;
  assign burst_done    = burst_done_q;
  assign rx_ovf        = rx_ovf_q;
  assign spi.spi_din   = spi_din_q;
  assign spi.spi_start = spi_start_q;

  // Burst sequencing: select setup, per-byte launch and wait, select hold.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    ss_n_d       = ss_n_q;
    spi_din_d    = spi_din_q;
    spi_start_d  = 1'b0;
    burst_done_d = 1'b0;
    rx_ovf_d     = rx_ovf_q;
    tx_pop       = 1'b0;
    rx_push      = 1'b0;
    case (state_q)
      IDLE: begin
        if (go && !tx_empty) begin
          ss_n_d   = ~(NUM_SS'(1) << ss_sel);
          rx_ovf_d = 1'b0;
          timer_d  = '0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        if (timer_q == TMR_W'(CS_DLY - 1)) begin
          state_d = LAUNCH;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      LAUNCH: begin
        if (spi.spi_ready && !tx_empty) begin
          tx_pop      = 1'b1;
          spi_din_d   = tx_mem_q[tx_rd_ptr_q];
          spi_start_d = 1'b1;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (spi.spi_done_tick) begin
          rx_push = 1'b1;
          if (tx_empty) begin
            timer_d = '0;
            state_d = HOLD;
          end else begin
            state_d = LAUNCH;
          end
        end
      end
      HOLD: begin
        if (timer_q == TMR_W'(CS_DLY - 1)) begin
          ss_n_d       = '1;
          burst_done_d = 1'b1;
          state_d      = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        ss_n_d  = '1;
        state_d = IDLE;
      end
    endcase
    if (rx_push && rx_full_w() && !rx_pop) begin
      rx_ovf_d = 1'b1;
    end
    busy_d = (state_d != IDLE);
  end

  // FIFO pointer and occupancy bookkeeping for both directions.
  always_comb begin
    tx_wr_ptr_d = tx_wr_ptr_q + (tx_push ? 1'b1 : 1'b0);
    tx_rd_ptr_d = tx_rd_ptr_q + (tx_pop ? 1'b1 : 1'b0);
    tx_cnt_d    = tx_cnt_q + (ADDR_W+1)'(tx_push) - (ADDR_W+1)'(tx_pop);
    rx_wr_ptr_d = rx_wr_ptr_q + (rx_write ? 1'b1 : 1'b0);
    rx_rd_ptr_d = rx_rd_ptr_q + (rx_pop ? 1'b1 : 1'b0);
    rx_cnt_d    = rx_cnt_q + (ADDR_W+1)'(rx_write) - (ADDR_W+1)'(rx_pop);
  end

  // Control and FIFO state registers; reset abandons any burst in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      ss_n_q       <= '1;
      spi_din_q    <= '0;
      spi_start_q  <= 1'b0;
      busy_q       <= 1'b0;
      burst_done_q <= 1'b0;
      rx_ovf_q     <= 1'b0;
      tx_wr_ptr_q  <= '0;
      tx_rd_ptr_q  <= '0;
      tx_cnt_q     <= '0;
      rx_wr_ptr_q  <= '0;
      rx_rd_ptr_q  <= '0;
      rx_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      ss_n_q       <= ss_n_d;
      spi_din_q    <= spi_din_d;
      spi_start_q  <= spi_start_d;
      busy_q       <= busy_d;
      burst_done_q <= burst_done_d;
      rx_ovf_q     <= rx_ovf_d;
      tx_wr_ptr_q  <= tx_wr_ptr_d;
      tx_rd_ptr_q  <= tx_rd_ptr_d;
      tx_cnt_q     <= tx_cnt_d;
      rx_wr_ptr_q  <= rx_wr_ptr_d;
      rx_rd_ptr_q  <= rx_rd_ptr_d;
      rx_cnt_q     <= rx_cnt_d;
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (tx_push) begin
      tx_mem_q[tx_wr_ptr_q] <= tx_data;
    end
    if (rx_write) begin
      rx_mem_q[rx_wr_ptr_q] <= spi.spi_dout;
    end
  end

endmodule
